// File: rtl/sz_fs_pkg.sv
// sz_fs_pkg
// Shared constants and types for the SZ first-stage predictor front end.
// The neighbour window feeder and the downstream 64-way mux wrapper both
// import this package, so the sample width, tap count, select width and
// mux latency stay consistent between the two.
//   WIDTH   : sample width in bits
//   DEPTH   : number of history taps (mux fan-in)
//   SEL_W   : select width, log2(DEPTH)
//   MUX_LAT : registered levels inside the downstream mux
//   state_t : frame FSM state
//   align_t : operand bundle delayed alongside the mux pipeline
package sz_fs_pkg;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int SEL_W   = 6;
    localparam int MUX_LAT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] left;
        logic             has_up;
        logic             has_left;
        logic             last;
    } align_t;

endpackage

// File: rtl/sz_neighbor_window_if.sv
// sz_neighbor_window_if
// Sample stream into the neighbour window feeder. There is no backpressure,
// so the stream is just a valid strobe with data and a frame-last marker.
//   in_valid : sample present this cycle
//   in_data  : sample value x[n]
//   in_last  : last sample of the frame, qualified by in_valid
// Modports: master drives the stream, slave (the feeder) receives it.
interface sz_neighbor_window_if;
    import sz_fs_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last
    );

    modport slave (
        input in_valid,
        input in_data,
        input in_last
    );

endinterface

// File: rtl/sz_align_pipe.sv
// sz_align_pipe
// Free-running W-bit delay line of LAT stages with a companion valid bit.
// It advances every cycle regardless of the valid bit so it tracks a
// free-running pipeline stage for stage.
//   clock  : rising-edge clock
//   aclr_n : asynchronous active-low reset, clears data and valid
//   din    : data entering the delay line
//   vin    : valid entering the delay line
//   dout   : din delayed LAT cycles
//   vout   : vin delayed LAT cycles
module sz_align_pipe #(
    parameter int W   = 8,
    parameter int LAT = 3
) (
    input  logic         clock,
    input  logic         aclr_n,
    input  logic [W-1:0] din,
    input  logic         vin,
    output logic [W-1:0] dout,
    output logic         vout
);

    logic [LAT-1:0][W-1:0] data_q;
    logic [LAT-1:0]        valid_q;

    // Shift data and valid one stage per clock; stage 0 takes the input.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= din;
            valid_q[0] <= vin;
            for (int i = 1; i < LAT; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign dout = data_q[LAT-1];
    assign vout = valid_q[LAT-1];

endmodule

// File: rtl/sz_neighbor_window.sv
// sz_neighbor_window
// Feeds the 64-way registered neighbour mux of the SZ first-stage predictor.
// Keeps the last DEPTH samples as a shift-register history, presents them as
// taps with a select pointing at the sample one row back, and delays the
// current sample, its left neighbour, the boundary flags and frame-last by
// the mux latency so every operand reaches the predictor on the same cycle.
//   clock      : rising-edge clock
//   aclr_n     : asynchronous active-low reset
//   in_if      : sample stream (slave modport)
//   cfg_stride : row length, 0 encodes DEPTH; sampled at frame start only
//   taps       : tap k = x[n-1-k] at bits [WIDTH*k +: WIDTH]
//   sel        : stride-1, index of the up neighbour among the taps
//   tap_valid  : taps/sel describe a new sample
//   cur_d      : x[n] delayed to line up with the mux result
//   left_d     : x[n-1] delayed to match
//   has_up_d   : up neighbour exists, delayed to match
//   has_left_d : left neighbour exists, delayed to match
//   last_d     : frame-last, delayed to match
//   out_valid  : tap_valid delayed to line up with the mux result
module sz_neighbor_window
    import sz_fs_pkg::*;
(
    input  logic                   clock,
    input  logic                   aclr_n,
    sz_neighbor_window_if.slave    in_if,
    input  logic [SEL_W-1:0]       cfg_stride,
    output logic [DEPTH*WIDTH-1:0] taps,
    output logic [SEL_W-1:0]       sel,
    output logic                   tap_valid,
    output logic [WIDTH-1:0]       cur_d,
    output logic [WIDTH-1:0]       left_d,
    output logic                   has_up_d,
    output logic                   has_left_d,
    output logic                   last_d,
    output logic                   out_valid
);

    state_t                      state_q;
    logic [SEL_W-1:0]            stride_q;
    logic [SEL_W-1:0]            col_q;
    logic                        row_q;
    logic [DEPTH-1:0][WIDTH-1:0] hist_q;
    logic [WIDTH-1:0]            cur_q;
    logic [SEL_W-1:0]            sel_q;
    logic                        tap_valid_q;
    logic                        has_up_q;
    logic                        has_left_q;
    logic                        last_q;

    logic                        frame_start;
    logic [SEL_W-1:0]            stride_eff;
    logic [SEL_W-1:0]            stride_m1;
    logic [SEL_W-1:0]            col_cur;
    logic                        row_cur;
    logic                        col_wrap;

    align_t                      bundle_in;
    align_t                      bundle_out;

    // A sample arriving in IDLE opens a frame, so it must already see the
    // new stride and cleared counters. Stride 0 wraps to all-ones on the
    // subtraction, which is exactly DEPTH-1 and gives the 64-wide row.
    always_comb begin
        frame_start = (state_q == IDLE);
        stride_eff  = frame_start ? cfg_stride : stride_q;
        stride_m1   = stride_eff - SEL_W'(1);
        col_cur     = frame_start ? '0 : col_q;
        row_cur     = frame_start ? 1'b0 : row_q;
        col_wrap    = (col_cur == stride_m1);
    end

    // Frame FSM, stride latch and position counters. The row counter only
    // needs to know whether the first row is finished, so it saturates at 1.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= IDLE;
            stride_q <= '0;
            col_q    <= '0;
            row_q    <= 1'b0;
        end else if (in_if.in_valid) begin
            if (frame_start) begin
                stride_q <= cfg_stride;
            end
            state_q <= in_if.in_last ? IDLE : RUN;
            col_q   <= col_wrap ? '0 : col_cur + SEL_W'(1);
            row_q   <= row_cur | col_wrap;
        end
    end

    // History, current sample, select and boundary flags update only on an
    // accepted sample and hold across gaps. History is never cleared between
    // frames; the flags tell the consumer which taps are meaningful.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            hist_q     <= '0;
            cur_q      <= '0;
            sel_q      <= '0;
            has_up_q   <= 1'b0;
            has_left_q <= 1'b0;
            last_q     <= 1'b0;
        end else if (in_if.in_valid) begin
            hist_q     <= {hist_q[DEPTH-2:0], cur_q};
            cur_q      <= in_if.in_data;
            sel_q      <= stride_m1;
            has_up_q   <= row_cur;
            has_left_q <= (col_cur != '0);
            last_q     <= in_if.in_last;
        end
    end

    // tap_valid follows in_valid every cycle so input gaps show up as gaps.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            tap_valid_q <= 1'b0;
        end else begin
            tap_valid_q <= in_if.in_valid;
        end
    end

    always_comb begin
        bundle_in          = '0;
        bundle_in.cur      = cur_q;
        bundle_in.left     = hist_q[0];
        bundle_in.has_up   = has_up_q;
        bundle_in.has_left = has_left_q;
        bundle_in.last     = last_q;
    end

    sz_align_pipe #(
        .W   ($bits(align_t)),
        .LAT (MUX_LAT)
    ) u_align (
        .clock  (clock),
        .aclr_n (aclr_n),
        .din    (bundle_in),
        .vin    (tap_valid_q),
        .dout   (bundle_out),
        .vout   (out_valid)
    );

    assign taps       = hist_q;
    assign sel        = sel_q;
    assign tap_valid  = tap_valid_q;
    assign cur_d      = bundle_out.cur;
    assign left_d     = bundle_out.left;
    assign has_up_d   = bundle_out.has_up;
    assign has_left_d = bundle_out.has_left;
    assign last_d     = bundle_out.last;

endmodule

// File: tb/tb_sz_neighbor_window.sv
// tb_sz_neighbor_window
// Directed bench for sz_neighbor_window. Inputs change 1 time unit after
// a rising edge and outputs are read at that same point, so a sample
// driven before edge E is visible on taps/sel at E+1 and on the aligned
// outputs three edges later.
module tb_sz_neighbor_window;
    import sz_fs_pkg::*;

    logic                   clock = 1'b0;
    logic                   aclr_n;
    logic [SEL_W-1:0]       cfg_stride;
    logic [DEPTH*WIDTH-1:0] taps;
    logic [SEL_W-1:0]       sel;
    logic                   tap_valid;
    logic [WIDTH-1:0]       cur_d;
    logic [WIDTH-1:0]       left_d;
    logic                   has_up_d;
    logic                   has_left_d;
    logic                   last_d;
    logic                   out_valid;

    int vectors     = 0;
    int miscompares = 0;

    sz_neighbor_window_if in_if ();

    sz_neighbor_window dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .in_if      (in_if),
        .cfg_stride (cfg_stride),
        .taps       (taps),
        .sel        (sel),
        .tap_valid  (tap_valid),
        .cur_d      (cur_d),
        .left_d     (left_d),
        .has_up_d   (has_up_d),
        .has_left_d (has_left_d),
        .last_d     (last_d),
        .out_valid  (out_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] getTap(input int k);
        return taps[WIDTH*k +: WIDTH];
    endfunction

    // Drive one cycle of stream input and advance to just after the edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic l);
        in_if.in_valid = v;
        in_if.in_data  = d;
        in_if.in_last  = l;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the delayed operand bundle for one sample.
    task automatic checkAligned(input string tag, input logic [WIDTH-1:0] c,
                                input logic [WIDTH-1:0] l, input logic up,
                                input logic lf, input logic last);
        checkOutput({tag, "_out_valid"}, out_valid, 1'b1);
        checkOutput({tag, "_cur_d"}, cur_d, c);
        checkOutput({tag, "_left_d"}, left_d, l);
        checkOutput({tag, "_has_up_d"}, has_up_d, up);
        checkOutput({tag, "_has_left_d"}, has_left_d, lf);
        checkOutput({tag, "_last_d"}, last_d, last);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_taps"}, 64'(|taps), 1'b0);
        checkOutput({tag, "_sel"}, sel, 0);
        checkOutput({tag, "_tap_valid"}, tap_valid, 1'b0);
        checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_cur_d"}, cur_d, 0);
        checkOutput({tag, "_left_d"}, left_d, 0);
        checkOutput({tag, "_has_up_d"}, has_up_d, 1'b0);
        checkOutput({tag, "_has_left_d"}, has_left_d, 1'b0);
        checkOutput({tag, "_last_d"}, last_d, 1'b0);
    endtask

    initial begin
        // Power-on reset
        aclr_n         = 1'b0;
        cfg_stride     = 6'd4;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        in_if.in_last  = 1'b0;
        #12;
        checkAllZero("reset");
        aclr_n = 1'b1;

        // Stride 4, samples 1..12 back to back, last on 12
        cfg_stride = 6'd4;
        for (int i = 1; i <= 16; i++) begin
            int j;
            if (i <= 12) applyStimulus(1'b1, WIDTH'(i), i == 12);
            else         applyStimulus(1'b0, '0, 1'b0);
            if (i <= 12) begin
                checkOutput("t1_tap_valid", tap_valid, 1'b1);
                checkOutput("t1_sel", sel, 3);
                checkOutput("t1_tap0", getTap(0), i - 1);
            end else begin
                checkOutput("t1_tap_valid_gap", tap_valid, 1'b0);
            end
            if (i == 6) begin
                for (int k = 0; k <= 4; k++)
                    checkOutput("t1_tap_k", getTap(k), 5 - k);
            end
            j = i - 3;
            if (j >= 1 && j <= 12)
                checkAligned("t1", WIDTH'(j), WIDTH'(j - 1), j > 4, ((j - 1) % 4) != 0, j == 12);
            else
                checkOutput("t1_out_idle", out_valid, 1'b0);
        end

        // in_valid toggling 1,0,1,0,1,0: samples 21,22,23, last on 23
        for (int s = 0; s <= 9; s++) begin
            logic v;
            logic vo;
            v = (s < 6) && ((s % 2) == 0);
            applyStimulus(v, v ? WIDTH'(21 + s / 2) : '0, v && (s == 4));
            checkOutput("t2_tap_valid", tap_valid, v);
            checkOutput("t2_tap0", getTap(0), (s < 2) ? 12 : ((s < 4) ? 21 : 22));
            vo = (s >= 3) && (s - 3 < 6) && (((s - 3) % 2) == 0);
            checkOutput("t2_out_valid", out_valid, vo);
            if (vo) checkOutput("t2_cur_d", cur_d, 21 + (s - 3) / 2);
        end

        // Back-to-back frames: A stride 4 (31..34), B stride 8 (41,42)
        cfg_stride = 6'd4;
        applyStimulus(1'b1, 31, 1'b0);
        checkOutput("t3_tap0_stale", getTap(0), 23);
        applyStimulus(1'b1, 32, 1'b0);
        applyStimulus(1'b1, 33, 1'b0);
        applyStimulus(1'b1, 34, 1'b1);
        checkOutput("t3_sel_a", sel, 3);
        checkAligned("t3_s31", 31, 23, 1'b0, 1'b0, 1'b0);
        cfg_stride = 6'd8;
        applyStimulus(1'b1, 41, 1'b0);
        checkOutput("t3_sel_b", sel, 7);
        checkOutput("t3_tap0_b", getTap(0), 34);
        checkOutput("t3_tap3_b", getTap(3), 31);
        applyStimulus(1'b1, 42, 1'b1);
        checkOutput("t3_sel_b2", sel, 7);
        applyStimulus(1'b0, '0, 1'b0);
        checkAligned("t3_s34", 34, 33, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkAligned("t3_s41", 41, 34, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkAligned("t3_s42", 42, 41, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t3_out_idle", out_valid, 1'b0);

        // Stride change mid-frame has no effect until the next frame
        cfg_stride = 6'd4;
        applyStimulus(1'b1, 51, 1'b0);
        cfg_stride = 6'd9;
        applyStimulus(1'b1, 52, 1'b0);
        checkOutput("t4_sel_hold", sel, 3);
        applyStimulus(1'b1, 53, 1'b1);
        checkOutput("t4_sel_hold2", sel, 3);
        applyStimulus(1'b1, 61, 1'b1);
        checkOutput("t4_sel_next", sel, 8);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkAligned("t4_s61", 61, 53, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Stride 0 encodes 64: 200 samples, last on 200
        cfg_stride = 6'd0;
        for (int i = 1; i <= 204; i++) begin
            int j;
            if (i <= 200) applyStimulus(1'b1, WIDTH'(i), i == 200);
            else          applyStimulus(1'b0, '0, 1'b0);
            if (i <= 200) checkOutput("t5_sel", sel, 63);
            if (i == 100) begin
                checkOutput("t5_tap63", getTap(63), 36);
                checkOutput("t5_tap0", getTap(0), 99);
            end
            j = i - 3;
            if (j >= 1 && j <= 200)
                checkAligned("t5", WIDTH'(j), (j == 1) ? 61 : WIDTH'(j - 1),
                             j > 64, ((j - 1) % 64) != 0, j == 200);
            else
                checkOutput("t5_out_idle", out_valid, 1'b0);
        end

        // Reset mid-frame with valids in flight
        cfg_stride = 6'd4;
        for (int i = 71; i <= 75; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0);
        checkOutput("t6_pre_out_valid", out_valid, 1'b1);
        #2;
        aclr_n = 1'b0;
        #1;
        checkAllZero("t6_async");
        #2;
        aclr_n = 1'b1;
        applyStimulus(1'b1, 81, 1'b0);
        checkOutput("t6_sel", sel, 3);
        checkOutput("t6_tap0", getTap(0), 0);
        checkOutput("t6_out_flushed0", out_valid, 1'b0);
        applyStimulus(1'b1, 82, 1'b0);
        checkOutput("t6_out_flushed1", out_valid, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t6_out_flushed2", out_valid, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkAligned("t6_s81", 81, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkAligned("t6_s82", 82, 81, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
